// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel RX with COM-symbol byte alignment; outputs update on the edge that samples a byte's last bit.
// No backpressure: one bit per clock in, each byte held on data_out/valid_out for 8 clocks.
module serial_paralelo_rx #(
  parameter logic [7:0] COM       = 8'hBC,
  parameter int         COM_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t      state;
  logic [6:0]  sh;
  logic [2:0]  bc;
  logic [3:0]  ccnt;
  logic [7:0]  w;
  logic        w_is_com;
  logic        boundary;

  // Byte completed by the bit currently being sampled.
  assign w        = {sh, data_in};
  assign w_is_com = (w == COM);
  assign boundary = (bc == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEARCH;
      sh        <= '0;
      bc        <= '0;
      ccnt      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sh <= w[6:0];
      bc <= bc + 3'd1;
      case (state)
        SEARCH: begin
          // Alignment point: bc restarts so the next boundary lands 8 edges later.
          if (w_is_com) begin
            bc   <= 3'd0;
            ccnt <= 4'd1;
            if (COM_COUNT == 1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= COUNT;
            end
          end
        end
        COUNT: begin
          if (boundary) begin
            if (w_is_com) begin
              ccnt <= ccnt + 4'd1;
              if ((ccnt + 4'd1) == 4'(COM_COUNT)) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              ccnt  <= 4'd0;
              state <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // Sticky: no loss-of-lock exit, only reset leaves this state.
          if (boundary) begin
            data_out  <= w;
            valid_out <= !w_is_com;
          end
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Directed bench for serial_paralelo_rx: lock, broken run, COM in data, false COM, reset mid-stream.
module tb_serial_paralelo_rx;

  logic       clk;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int checks = 0;
  int errors = 0;

  serial_paralelo_rx dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, v});
    chk({tag, ".active"}, {7'd0, active}, {7'd0, a});
  endtask

  // Drive one bit, let it be sampled, then sit 1 time unit past the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Send a byte MSB first. First 7 bits: outputs must still hold the previous
  // values; after the last bit: the new values.
  task automatic send_byte(input string tag, input logic [7:0] b,
                           input logic [7:0] pd, input logic pv, input logic pa,
                           input logic [7:0] nd, input logic nv, input logic na);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0) chk_out({tag, ".hold"}, pd, pv, pa);
      else        chk_out({tag, ".end"}, nd, nv, na);
    end
  endtask

  task automatic do_reset();
    data_in = 1'b0;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_out("rst_hold", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;

    // Reset held with random data: outputs stay clear.
    for (int i = 0; i < 12; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk_out("rst_rand", 8'h00, 1'b0, 1'b0);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b0);
      chk_out("idle_zero", 8'h00, 1'b0, 1'b0);
    end

    // Basic lock after 3 random bits.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    send_byte("lock_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("lock_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("lock_bc3", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("lock_bc4", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    send_byte("lock_ff",  8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
    send_byte("lock_dd",  8'hDD, 8'hFF, 1'b1, 1'b1, 8'hDD, 1'b1, 1'b1);
    send_byte("lock_ee",  8'hEE, 8'hDD, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    send_byte("lock_cc",  8'hCC, 8'hEE, 1'b1, 1'b1, 8'hCC, 1'b1, 1'b1);

    // Broken run: the 55 breaks the count, second run locks.
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_byte("brk_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("brk_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("brk_bc3", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("brk_55",  8'h55, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("run2_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("run2_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("run2_bc3", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("run2_bc4", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    send_byte("run2_77",  8'h77, 8'h00, 1'b0, 1'b1, 8'h77, 1'b1, 1'b1);

    // COM inside the data stream drops valid for one byte time.
    send_byte("com_99", 8'h99, 8'h77, 1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    send_byte("com_bc", 8'hBC, 8'h99, 1'b1, 1'b1, 8'hBC, 1'b0, 1'b1);
    send_byte("com_aa", 8'hAA, 8'hBC, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1);

    // 0B C0 hides a BC pattern across the boundary; alignment must not move.
    send_byte("false_0b", 8'h0B, 8'hAA, 1'b1, 1'b1, 8'h0B, 1'b1, 1'b1);
    send_byte("false_c0", 8'hC0, 8'h0B, 1'b1, 1'b1, 8'hC0, 1'b1, 1'b1);
    send_byte("false_5a", 8'h5A, 8'hC0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);

    // Reset 3 bits into byte 88: outputs clear without a clock edge.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    chk_out("mid_pre", 8'h5A, 1'b1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk_out("mid_async", 8'h00, 1'b0, 1'b0);
    data_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_out("mid_held", 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    send_byte("re_bc1", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("re_bc2", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("re_bc3", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    send_byte("re_bc4", 8'hBC, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    send_byte("re_12",  8'h12, 8'h00, 1'b0, 1'b1, 8'h12, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
# serial_paralelo_rx

Receive-side serial-to-parallel converter and symbol aligner for the PHY RX path. It shifts in one bit per clock (MSB first) and finds byte alignment on the COM symbol (0xBC). After a run of consecutive aligned COMs it declares the link active. It then presents each received byte on an 8-bit bus with a valid flag: this is the byte stream (data plus valid) consumed by the downstream 1x4 byte demux.

## Interface
Parameters:
- COM, 8'hBC: comma/idle symbol used for alignment and stripped from the valid stream
- COM_COUNT, 4: consecutive aligned COMs required to enter ACTIVE (legal range 1-15)

Ports:
- clk  in  1  bit clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- data_in  in  1  serial data, MSB of each byte first, sampled on posedge clk
- data_out  out  8  last assembled byte, held for 8 clocks
- valid_out  out  1  high while data_out holds a non-COM byte received in ACTIVE
- active  out  1  link-aligned indicator, high from entry into ACTIVE until reset

## Operation
- Shift register: on every edge, sh <= {sh[6:0], data_in}. Window w = {sh[6:0], data_in} is the byte completed by the bit being sampled.
- Bit counter bc runs 0..7 and wraps 7->0. A byte boundary is an edge with bc==7.
- Counter ccnt holds the number of aligned COMs, 4 bits, saturating at COM_COUNT.
- SEARCH (reset state):
  - The window w is compared on every edge, with no reference to bc.
  - On w==COM: bc <= 0 (this edge is the alignment point) and ccnt <= 1.
  - If COM_COUNT==1, go to ACTIVE. Otherwise go to COUNT.
  - On no match, remain in SEARCH.
- COUNT:
  - Only boundary edges are evaluated. A COM-pattern window off a boundary is ignored.
  - At a boundary with w==COM: ccnt <= ccnt+1. If ccnt+1==COM_COUNT, go to ACTIVE.
  - At a boundary with w!=COM: ccnt <= 0 and return to SEARCH. The search resumes on the next edge.
- ACTIVE:
  - active <= 1 on the transition edge. Active is sticky until reset; there is no loss-of-lock exit.
  - At each boundary: data_out <= w and valid_out <= (w != COM).
  - Between boundaries, data_out and valid_out hold their values.
  - The COM byte that completes the lock sequence is not output: data_out and valid_out stay 0 on that edge.
- data_out and valid_out never change outside ACTIVE.
- Reset (asynchronous, mid-operation included):
  - Outputs go to 0 and the state goes to SEARCH.
  - sh, bc and ccnt are all cleared.
  - No partially assembled byte survives reset.

## Timing
- Reset values: data_out=8'h00, valid_out=0, active=0.
- Alignment latency:
  - Let edge E0 sample the last bit of the first COM.
  - COM number k completes on edge E0+8(k-1).
  - active rises on edge E0+8(COM_COUNT-1). With the default, that is E0+24.
- Data latency: the first data byte completes at E0+8·COM_COUNT. data_out and valid_out update on that same edge, which gives a 0-cycle registered latency from the last bit sampled.
- Each byte is presented for exactly 8 clocks.
- valid_out is a level signal, not a pulse. For back-to-back data bytes it stays high continuously.
- A COM byte in ACTIVE drops valid_out for exactly those 8 clocks. data_out shows 8'hBC during that time.
- Outputs are registered. No combinational path runs from data_in to any output.

## Test plan
- Reset check: hold reset=0 with random data_in, then release. Required: data_out=00, valid_out=0 and active=0 throughout, and all three remain 0 while data_in=0 continuously.
- Basic lock: send 3 random bits, then BC BC BC BC FF DD EE CC. Required:
  - active rises on the edge sampling the last bit of the 4th BC.
  - data_out shows FF, DD, EE, CC, 8 clocks each, with valid_out=1 continuously from the FF edge.
- Broken run: send BC BC BC 55, then BC BC BC BC 77. Required:
  - After 55, the state returns to SEARCH and active stays 0.
  - Lock is achieved only on the second run, and 77 appears with valid_out=1.
- COM in data: after lock, send 99 BC AA. Required: valid_out=1 for 99, 0 for 8 clocks with data_out=BC, then 1 for AA. active stays 1.
- False COM off boundary: after lock, send bytes 0B C0 (bit stream contains BC straddling the boundary). Required: data_out=0B then C0, both valid, and alignment unchanged.
- Reset mid-stream: assert reset 3 clocks into byte 88 in ACTIVE. Required:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, 4 fresh BCs are needed before any valid_out.
